// File: rtl/lif_neuron_n.sv
// ============================================================================
// Module   : lif_neuron_n
// Brief    : N-input leaky integrate-and-fire neuron with saturating potential,
//            symmetric leak, refractory period and saturating spike counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lif_neuron_n #(
    parameter int N_IN    = 4,
    parameter int DW      = 8,
    parameter int VW      = 16,
    parameter int LEAK    = 1,
    parameter int VTH     = 30,
    parameter int V_RESET = 0,
    parameter int REFRAC  = 2,
    parameter int CW      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [N_IN*DW-1:0]     a,
    input  logic [N_IN*DW-1:0]     w,
    input  logic [DW-1:0]          bias,
    input  logic                   cnt_clr,
    output logic signed [VW-1:0]   vp,
    output logic                   spike,
    output logic                   refractory,
    output logic [CW-1:0]          spike_cnt
);

    localparam int SW = 2*DW + $clog2(N_IN) + 1;
    localparam int EW = ((SW > VW) ? SW : VW) + 1;
    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    localparam logic signed [VW-1:0] ZERO_V  = '0;
    localparam logic signed [VW-1:0] LEAK_V  = VW'(LEAK);
    localparam logic signed [VW-1:0] VTH_V   = VW'(VTH);
    localparam logic signed [VW-1:0] VRST_V  = VW'(V_RESET);
    localparam logic signed [EW-1:0] VMAX_E  = EW'({1'b0, {(VW-1){1'b1}}});
    localparam logic signed [EW-1:0] VMIN_E  = ~VMAX_E;
    localparam logic [RW-1:0]        REF_V   = RW'(REFRAC);
    localparam logic [CW-1:0]        CMAX    = '1;

    logic signed [VW-1:0] vp_q, vp_d;
    logic                 spike_q, spike_d;
    logic [RW-1:0]        ref_q, ref_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic signed [DW-1:0]   ai, wi;
    logic signed [2*DW-1:0] prod;
    logic signed [SW-1:0]   sum;
    logic signed [EW-1:0]   v1_e;
    logic signed [VW-1:0]   v1, v2;

    always_comb begin
        ai   = '0;
        wi   = '0;
        prod = '0;
        sum  = SW'(signed'(bias));
        for (int i = 0; i < N_IN; i++) begin
            ai   = signed'(a[i*DW +: DW]);
            wi   = signed'(w[i*DW +: DW]);
            prod = ai * wi;
            sum  = sum + SW'(prod);
        end

        // Widened add so the clamp sees the true value before narrowing.
        v1_e = EW'(vp_q) + EW'(sum);
        if (v1_e > VMAX_E)
            v1 = VW'(VMAX_E);
        else if (v1_e < VMIN_E)
            v1 = VW'(VMIN_E);
        else
            v1 = VW'(v1_e);

        if (v1 > ZERO_V)
            v2 = (v1 > LEAK_V) ? v1 - LEAK_V : ZERO_V;
        else if (v1 < ZERO_V)
            v2 = (v1 < -LEAK_V) ? v1 + LEAK_V : ZERO_V;
        else
            v2 = ZERO_V;

        vp_d    = vp_q;
        spike_d = 1'b0;
        ref_d   = ref_q;
        cnt_d   = cnt_q;
        if (in_valid) begin
            if (ref_q != '0) begin
                vp_d  = VRST_V;
                ref_d = ref_q - 1'b1;
            end else if (v2 > VTH_V) begin
                spike_d = 1'b1;
                vp_d    = VRST_V;
                ref_d   = REF_V;
                if (cnt_q != CMAX)
                    cnt_d = cnt_q + 1'b1;
            end else begin
                vp_d = v2;
            end
        end
        if (cnt_clr)
            cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vp_q    <= '0;
            spike_q <= 1'b0;
            ref_q   <= '0;
            cnt_q   <= '0;
        end else begin
            vp_q    <= vp_d;
            spike_q <= spike_d;
            ref_q   <= ref_d;
            cnt_q   <= cnt_d;
        end
    end

    assign vp         = vp_q;
    assign spike      = spike_q;
    assign refractory = (ref_q != '0);
    assign spike_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_lif_neuron_n.sv
// ============================================================================
// Module   : tb_lif_neuron_n
// Brief    : Directed scoreboard bench for lif_neuron_n (default, saturation
//            and 2-bit counter instances share one stimulus bus).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lif_neuron_n;

    localparam int N_IN = 4;
    localparam int DW   = 8;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic [N_IN*DW-1:0]   a;
    logic [N_IN*DW-1:0]   w;
    logic [DW-1:0]        bias;
    logic                 cnt_clr;

    logic signed [15:0]   vp0, vp1, vp2;
    logic                 spk0, spk1, spk2;
    logic                 rf0, rf1, rf2;
    logic [15:0]          cnt0, cnt1;
    logic [1:0]           cnt2;

    typedef struct {
        string tag;
        int    inst;
        int    vp;
        int    spk;
        int    rf;
        int    cnt;
    } exp_t;

    exp_t sbq[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    lif_neuron_n dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .w(w), .bias(bias),
        .cnt_clr(cnt_clr), .vp(vp0), .spike(spk0), .refractory(rf0), .spike_cnt(cnt0)
    );

    lif_neuron_n #(.VTH(32767)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .w(w), .bias(bias),
        .cnt_clr(cnt_clr), .vp(vp1), .spike(spk1), .refractory(rf1), .spike_cnt(cnt1)
    );

    lif_neuron_n #(.CW(2)) dut_cw2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .w(w), .bias(bias),
        .cnt_clr(cnt_clr), .vp(vp2), .spike(spk2), .refractory(rf2), .spike_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exv);
        n_assert++;
        assert (obs === exv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exv);
        end
    endtask

    task automatic set_in(input int a0, input int w0, input int rest_a, input int rest_w, input int b);
        for (int i = 0; i < N_IN; i++) begin
            a[i*DW +: DW] = (i == 0) ? DW'(a0) : DW'(rest_a);
            w[i*DW +: DW] = (i == 0) ? DW'(w0) : DW'(rest_w);
        end
        bias = DW'(b);
    endtask

    task automatic step(input logic r, input logic v, input logic clr, input string tag,
                        input int inst, input int evp, input int espk, input int erf, input int ecnt);
        exp_t e;
        logic signed [31:0] ovp, ospk, orf, ocnt;
        rst      = r;
        in_valid = v;
        cnt_clr  = clr;
        sbq.push_back('{tag, inst, evp, espk, erf, ecnt});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        case (e.inst)
            1:       begin ovp = 32'(vp1); ospk = 32'(spk1); orf = 32'(rf1); ocnt = 32'(cnt1); end
            2:       begin ovp = 32'(vp2); ospk = 32'(spk2); orf = 32'(rf2); ocnt = 32'(cnt2); end
            default: begin ovp = 32'(vp0); ospk = 32'(spk0); orf = 32'(rf0); ocnt = 32'(cnt0); end
        endcase
        chk({e.tag, ".vp"},  ovp,  e.vp);
        chk({e.tag, ".spk"}, ospk, e.spk);
        chk({e.tag, ".rf"},  orf,  e.rf);
        chk({e.tag, ".cnt"}, ocnt, e.cnt);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; cnt_clr = 1'b0;
        set_in(55, 3, 55, 3, 7);
        #1;

        // Reset with live, nonzero inputs.
        step(1, 1, 0, "rst0", 0, 0, 0, 0, 0);
        step(1, 1, 1, "rst1", 0, 0, 0, 0, 0);

        // Integrate and fire.
        set_in(1, 10, 0, 0, 0);
        step(0, 1, 0, "int1", 0,  9, 0, 0, 0);
        step(0, 1, 0, "int2", 0, 18, 0, 0, 0);
        step(0, 1, 0, "int3", 0, 27, 0, 0, 0);
        step(0, 1, 0, "fire", 0,  0, 1, 1, 1);

        // Refractory stretched by in_valid gaps.
        step(0, 1, 0, "ref_b1",  0, 0, 0, 1, 1);
        step(0, 0, 0, "ref_g1",  0, 0, 0, 1, 1);
        step(0, 1, 0, "ref_b2",  0, 0, 0, 0, 1);
        step(0, 0, 0, "ref_g2",  0, 0, 0, 0, 1);
        step(0, 1, 0, "ref_int", 0, 9, 0, 0, 1);
        step(0, 0, 0, "idle",    0, 9, 0, 0, 1);

        // Negative potential leaks back toward zero.
        step(1, 0, 0, "rst_n", 0, 0, 0, 0, 0);
        set_in(1, -5, 0, 0, 0);
        step(0, 1, 0, "neg1", 0, -4, 0, 0, 0);
        step(0, 1, 0, "neg2", 0, -8, 0, 0, 0);
        set_in(1, 0, 0, 0, 0);
        step(0, 1, 0, "leak1", 0, -7, 0, 0, 0);
        step(0, 1, 0, "leak2", 0, -6, 0, 0, 0);
        step(0, 1, 0, "leak3", 0, -5, 0, 0, 0);

        // Saturation on the high-threshold instance.
        step(1, 0, 0, "rst_s", 1, 0, 0, 0, 0);
        set_in(127, 127, 127, 127, 0);
        step(0, 1, 0, "satp1", 1, 32766, 0, 0, 0);
        step(0, 1, 0, "satp2", 1, 32766, 0, 0, 0);
        step(1, 0, 0, "rst_s2", 1, 0, 0, 0, 0);
        set_in(127, -128, 127, -128, 0);
        step(0, 1, 0, "satn", 1, -32767, 0, 0, 0);

        // Counter clear wins over a simultaneous spike.
        step(1, 0, 0, "rst_c", 0, 0, 0, 0, 0);
        set_in(1, 10, 0, 0, 0);
        step(0, 1, 0, "c_int1", 0,  9, 0, 0, 0);
        step(0, 1, 0, "c_int2", 0, 18, 0, 0, 0);
        step(0, 1, 0, "c_int3", 0, 27, 0, 0, 0);
        step(0, 1, 1, "c_clr",  0,  0, 1, 1, 0);

        // Reset mid-refractory, then integrate immediately.
        step(0, 1, 0, "r_ref",  0, 0, 0, 1, 0);
        step(1, 1, 0, "r_rst",  0, 0, 0, 0, 0);
        step(0, 1, 0, "r_int",  0, 9, 0, 0, 0);

        // Two-bit counter saturates at 3.
        step(1, 0, 0, "rst_k", 2, 0, 0, 0, 0);
        set_in(127, 127, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            step(0, 1, 0, $sformatf("k%0d_fire", k), 2, 0, 1, 1, (k < 3) ? k : 3);
            step(0, 1, 0, $sformatf("k%0d_r1", k),   2, 0, 0, 1, (k < 3) ? k : 3);
            step(0, 1, 0, $sformatf("k%0d_r2", k),   2, 0, 0, 0, (k < 3) ? k : 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
